// File: rtl/bitslice_packer.sv
// Collects k (m+n)-bit samples, transposes them into bit-slices and loads them into the bit-serial accumulator with a one-cycle pl.
// Optional status outputs (frames_sent, stall) exist only when PACKER_STATUS_EN is defined.
module bitslice_packer #(
  parameter int m = 3,
  parameter int n = 2,
  parameter int k = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [m+n-1:0]       in_data,
  output logic                 in_ready,
  input  logic                 acc_ready,
  output logic                 pl,
  output logic [(m+n)*k-1:0]   dout
`ifdef PACKER_STATUS_EN
  ,
  output logic [15:0]          frames_sent,
  output logic                 stall
`endif
);

  localparam int W  = m + n;
  localparam int CW = $clog2(k + 2);
  localparam logic [CW-1:0] K_CNT      = CW'(k);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(k + 1);

  logic [k-1:0][W-1:0] fill_q, fill_d;
  logic [CW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                hold_full_q, hold_full_d;
  logic [W*k-1:0]      hold_q, hold_d;
  logic [W*k-1:0]      xpose;
  logic                accept;
  logic                xfer;

  assign in_ready = (fill_cnt_q < K_CNT);
  assign accept   = in_valid && in_ready;
  assign pl       = hold_full_q && acc_ready && (gap_cnt_q == '0);
  // A full fill buffer moves to hold when hold is empty or is being emptied by pl now.
  assign xfer     = (fill_cnt_q == K_CNT) && (!hold_full_q || pl);
  assign dout     = hold_q;

  always_comb begin
    xpose = '0;
    for (int b = 0; b < W; b++) begin
      for (int j = 0; j < k; j++) begin
        xpose[b*k + j] = fill_q[j][b];
      end
    end
  end

  always_comb begin
    fill_d      = fill_q;
    fill_cnt_d  = fill_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    gap_cnt_d   = gap_cnt_q;

    for (int j = 0; j < k; j++) begin
      if (accept && (fill_cnt_q == CW'(j))) begin
        fill_d[j] = in_data;
      end
    end

    if (xfer) begin
      fill_cnt_d = '0;
    end else if (accept) begin
      fill_cnt_d = fill_cnt_q + CW'(1);
    end

    if (xfer) begin
      hold_d      = xpose;
      hold_full_d = 1'b1;
    end else if (pl) begin
      hold_full_d = 1'b0;
    end

    // Holds off the next load until the accumulator's k+1 shift/add cycles are done.
    if (pl) begin
      gap_cnt_d = GAP_RELOAD;
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q      <= '0;
      fill_cnt_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_cnt_q  <= fill_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef PACKER_STATUS_EN
  logic [15:0] frames_sent_q, frames_sent_d;
  logic        stall_q, stall_d;

  always_comb begin
    frames_sent_d = pl ? frames_sent_q + 16'd1 : frames_sent_q;
    stall_d       = hold_full_q && !pl;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames_sent_q <= '0;
      stall_q       <= 1'b0;
    end else begin
      frames_sent_q <= frames_sent_d;
      stall_q       <= stall_d;
    end
  end

  assign frames_sent = frames_sent_q;
  assign stall       = stall_q;
`endif

endmodule
